regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 64, giving the register data width in bits.
REQ-002 SHALL provide parameter NREG, default 32, giving the register count; legal values are powers of two, 2..64.
REQ-003 SHALL provide parameter BYPASS, default 1, which enables write-to-read forwarding when 1.
REQ-004 SHALL derive localparam AW = clog2(NREG) for all register-index ports.
REQ-005 SHALL provide port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-006 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL provide ports rs1 and rs2, input, AW bits each: read-port indices.
REQ-008 SHALL provide ports ReadData1 and ReadData2, output, XLEN bits each: read-port data.
REQ-009 SHALL provide ports rs1_busy and rs2_busy, output, 1 bit each: the source register has a pending write.
REQ-010 SHALL provide ports wr_en (1 bit), wr_addr (AW bits) and wr_data (XLEN bits), all inputs: the writeback port.
REQ-011 SHALL provide ports issue_en (1 bit) and issue_rd (AW bits), inputs: an instruction requests issue with destination issue_rd.
REQ-012 SHALL provide port issue_stall, output, 1 bit: the issue request is refused this cycle.
REQ-013 SHALL provide port flush, input, 1 bit: discard all pending-write marks.
REQ-014 SHALL provide port busy_count, output, AW+1 bits: number of registers currently marked pending.

Function
REQ-015 SHALL hold NREG x XLEN storage plus one busy bit per register.
REQ-016 SHALL write wr_data to register wr_addr on the rising clk edge when wr_en=1 and wr_addr!=0.
REQ-017 SHALL ignore writes to register 0, so that register 0 always reads 0 and busy[0] is always 0.
REQ-018 SHALL make reads combinational: ReadDataN = reg[rsN], or 0 when rsN=0.
REQ-019 SHALL, when BYPASS=1 and wr_en=1 and wr_addr=rsN!=0, drive ReadDataN = wr_data in that same cycle.
REQ-020 SHALL, when BYPASS=0 under the same conditions, return the old register value, with the new value visible the cycle after.
REQ-021 SHALL drive rsN_busy = busy[rsN], except that it SHALL be 0 when BYPASS=1 and the same-cycle write targets rsN.
REQ-022 SHALL assert issue_stall = issue_en AND (rs1_busy OR rs2_busy OR busy[issue_rd]), where the busy[issue_rd] term is the WAW check and the bypass exception of REQ-021 also applies to issue_rd.
REQ-023 SHALL treat an issue as accepted when issue_en=1 and issue_stall=0; on acceptance, set busy[issue_rd] at the clock edge unless issue_rd=0.
REQ-024 SHALL clear busy[wr_addr] at the clock edge whenever wr_en=1.
REQ-025 SHALL give set priority when the same register is both set by an accepted issue and cleared by a write in the same cycle, leaving it busy.
REQ-026 SHALL clear all busy bits at the clock edge when flush=1, with priority over any issue set that cycle; register writes still occur during flush.
REQ-027 SHALL register busy_count, which SHALL equal the popcount of the busy bits after each edge and never exceed NREG-1.
REQ-028 SHALL keep issue_stall purely combinational, with no added latency.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear all registers to 0, all busy bits to 0, and busy_count to 0.
REQ-030 SHALL hold ReadData1 and ReadData2 at 0, rsN_busy at 0 and issue_stall at 0 during reset, regardless of inputs.
REQ-031 SHALL abandon any pending marks on reset assertion mid-operation; after release, the first edge behaves as from the power-up state.

Verification
REQ-032 SHALL cover write-then-read: wr x5=0xDEAD_BEEF, next cycle rs1=5 -> ReadData1=0xDEAD_BEEF; wr x0=0x1234 -> rs2=0 reads 0.
REQ-033 SHALL cover bypass: with BYPASS=1 and the same cycle wr_en, wr_addr=7, wr_data=0x55, rs2=7 -> ReadData2=0x55 and rs2_busy=0; with BYPASS=0 -> old value returned.
REQ-034 SHALL cover RAW stall: issue rd=3 accepted, then issue_en with rs1=3 -> issue_stall=1 until the cycle wr_addr=3 arrives, then 0; busy_count goes 1 -> 0.
REQ-035 SHALL cover WAW plus simultaneous set/clear: busy[4] set, issue rd=4 -> stall; in the cycle wr x4 and issue rd=4 coincide -> no stall, busy[4]=1, busy_count unchanged.
REQ-036 SHALL cover flush: mark x1, x2 and x9 busy (busy_count=3), then flush with a concurrent issue rd=10 -> all busy bits 0 and busy_count=0 next cycle.
REQ-037 SHALL cover async reset mid-operation: pull reset low between edges -> registers and busy_count read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with pending-write scoreboard and issue interlock
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NREG)-1:0]   rs1,
    input  logic [$clog2(NREG)-1:0]   rs2,
    output logic [XLEN-1:0]           ReadData1,
    output logic [XLEN-1:0]           ReadData2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      wr_en,
    input  logic [$clog2(NREG)-1:0]   wr_addr,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      issue_en,
    input  logic [$clog2(NREG)-1:0]   issue_rd,
    output logic                      issue_stall,
    input  logic                      flush,
    output logic [$clog2(NREG):0]     busy_count
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     count_next;

    logic byp1, byp2, bypd;
    logic rd_busy;
    logic accept;

    // A same-cycle write to a register both forwards its data and hides its pending mark.
    assign byp1 = (BYPASS != 0) && wr_en && (wr_addr == rs1)      && (rs1 != '0);
    assign byp2 = (BYPASS != 0) && wr_en && (wr_addr == rs2)      && (rs2 != '0);
    assign bypd = (BYPASS != 0) && wr_en && (wr_addr == issue_rd) && (issue_rd != '0);

    always_comb begin
        ReadData1 = '0;
        if (reset && (rs1 != '0)) begin
            ReadData1 = byp1 ? wr_data : regs[rs1];
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (reset && (rs2 != '0)) begin
            ReadData2 = byp2 ? wr_data : regs[rs2];
        end
    end

    assign rs1_busy    = reset && busy[rs1] && !byp1;
    assign rs2_busy    = reset && busy[rs2] && !byp2;
    assign rd_busy     = busy[issue_rd] && !bypd;
    assign issue_stall = reset && issue_en && (rs1_busy || rs2_busy || rd_busy);
    assign accept      = issue_en && !issue_stall;

    // Order matters: writeback clear, then issue set (set wins), then flush (wins over all).
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (accept && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < NREG; i++) begin
            count_next = count_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - vector table and scoreboard bench for regfile_scoreboard
module tb_regfile_scoreboard;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [AW-1:0]   rs1, rs2, wr_addr, issue_rd;
    logic            wr_en, issue_en, flush;
    logic [XLEN-1:0] wr_data;

    logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic            b1_b, b2_b, st_b, b1_n, b2_n, st_n;
    logic [AW:0]     cnt_b, cnt_n;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .rs1_busy(b1_b), .rs2_busy(b2_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_stall(st_b),
        .flush(flush), .busy_count(cnt_b)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .rs1_busy(b1_n), .rs2_busy(b2_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_stall(st_n),
        .flush(flush), .busy_count(cnt_n)
    );

    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   r1;
        logic [AW-1:0]   r2;
        logic            ie;
        logic [AW-1:0]   ird;
        logic            fl;
    } stim_t;

    typedef struct {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic            b1;
        logic            b2;
        logic            stall;
        logic [AW:0]     cnt;
        logic [XLEN-1:0] rd2_nb;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t vecs[24];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic we, input int wa, input logic [XLEN-1:0] wd,
                                input int r1, input int r2, input logic ie, input int ird,
                                input logic fl, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                                input logic eb1, input logic eb2, input logic est, input int ec,
                                input logic [XLEN-1:0] e2nb);
        vec_t v;
        v.s.we  = we;          v.s.wa = AW'(wa);  v.s.wd  = wd;
        v.s.r1  = AW'(r1);     v.s.r2 = AW'(r2);  v.s.ie  = ie;
        v.s.ird = AW'(ird);    v.s.fl = fl;
        v.e.rd1 = e1;          v.e.rd2 = e2;      v.e.b1 = eb1;  v.e.b2 = eb2;
        v.e.stall = est;       v.e.cnt = (AW+1)'(ec);  v.e.rd2_nb = e2nb;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        wr_en    = s.we;
        wr_addr  = s.wa;
        wr_data  = s.wd;
        rs1      = s.r1;
        rs2      = s.r2;
        issue_en = s.ie;
        issue_rd = s.ird;
        flush    = s.fl;
    endtask

    task automatic compare(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
        end else begin
            n_checks--;
            e = sb.pop_front();
            compare({tag, ".rd1"},    rd1_b,                e.rd1);
            compare({tag, ".rd2"},    rd2_b,                e.rd2);
            compare({tag, ".b1"},     XLEN'(b1_b),          XLEN'(e.b1));
            compare({tag, ".b2"},     XLEN'(b2_b),          XLEN'(e.b2));
            compare({tag, ".stall"},  XLEN'(st_b),          XLEN'(e.stall));
            compare({tag, ".cnt"},    XLEN'(cnt_b),         XLEN'(e.cnt));
            compare({tag, ".rd2_nb"}, rd2_n,                e.rd2_nb);
        end
    endtask

    function automatic exp_t ex(input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2,
                                input logic eb1, input logic eb2, input logic est, input int ec,
                                input logic [XLEN-1:0] e2nb);
        exp_t e;
        e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2;
        e.stall = est; e.cnt = (AW+1)'(ec); e.rd2_nb = e2nb;
        return e;
    endfunction

    initial begin
        //        we wa wd            r1 r2 ie ird fl   rd1           rd2    b1 b2 st cnt rd2_nb
        vecs[0]  = mk(0, 0, 64'h0,        0, 0, 0, 0, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[1]  = mk(1, 5, 64'hDEADBEEF, 0, 0, 0, 0, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[2]  = mk(1, 0, 64'h1234,     5, 0, 0, 0, 0,  64'hDEADBEEF, 64'h0,    0, 0, 0, 0, 64'h0);
        vecs[3]  = mk(1, 7, 64'h77,       0, 0, 1, 7, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[4]  = mk(1, 7, 64'h55,       5, 7, 0, 0, 0,  64'hDEADBEEF, 64'h55,   0, 0, 0, 1, 64'h77);
        vecs[5]  = mk(0, 0, 64'h0,        0, 7, 0, 0, 0,  64'h0,        64'h55,   0, 0, 0, 0, 64'h55);
        vecs[6]  = mk(0, 0, 64'h0,        0, 0, 1, 3, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[7]  = mk(0, 0, 64'h0,        3, 0, 1, 0, 0,  64'h0,        64'h0,    1, 0, 1, 1, 64'h0);
        vecs[8]  = mk(0, 0, 64'h0,        3, 0, 1, 0, 0,  64'h0,        64'h0,    1, 0, 1, 1, 64'h0);
        vecs[9]  = mk(1, 3, 64'hAAAA,     3, 0, 1, 0, 0,  64'hAAAA,     64'h0,    0, 0, 0, 1, 64'h0);
        vecs[10] = mk(0, 0, 64'h0,        3, 0, 0, 0, 0,  64'hAAAA,     64'h0,    0, 0, 0, 0, 64'h0);
        vecs[11] = mk(0, 0, 64'h0,        0, 0, 1, 4, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[12] = mk(0, 0, 64'h0,        0, 0, 1, 4, 0,  64'h0,        64'h0,    0, 0, 1, 1, 64'h0);
        vecs[13] = mk(1, 4, 64'h44,       0, 0, 1, 4, 0,  64'h0,        64'h0,    0, 0, 0, 1, 64'h0);
        vecs[14] = mk(0, 0, 64'h0,        4, 0, 1, 4, 0,  64'h44,       64'h0,    1, 0, 1, 1, 64'h0);
        vecs[15] = mk(1, 4, 64'h45,       0, 0, 0, 0, 0,  64'h0,        64'h0,    0, 0, 0, 1, 64'h0);
        vecs[16] = mk(0, 0, 64'h0,        4, 0, 0, 0, 0,  64'h45,       64'h0,    0, 0, 0, 0, 64'h0);
        vecs[17] = mk(0, 0, 64'h0,        0, 0, 1, 1, 0,  64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[18] = mk(0, 0, 64'h0,        0, 0, 1, 2, 0,  64'h0,        64'h0,    0, 0, 0, 1, 64'h0);
        vecs[19] = mk(0, 0, 64'h0,        0, 0, 1, 9, 0,  64'h0,        64'h0,    0, 0, 0, 2, 64'h0);
        vecs[20] = mk(0, 0, 64'h0,        1, 9, 0, 0, 0,  64'h0,        64'h0,    1, 1, 0, 3, 64'h0);
        vecs[21] = mk(0, 0, 64'h0,        0, 0, 1, 10, 1, 64'h0,        64'h0,    0, 0, 0, 3, 64'h0);
        vecs[22] = mk(0, 0, 64'h0,        1, 9, 1, 10, 0, 64'h0,        64'h0,    0, 0, 0, 0, 64'h0);
        vecs[23] = mk(0, 0, 64'h0,        0, 0, 1, 10, 0, 64'h0,        64'h0,    0, 0, 1, 1, 64'h0);

        // Held in reset with an active bypassing write and issue: every output must stay 0.
        drive(mk(1, 5, 64'hFFFF, 5, 5, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0).s);
        #3;
        sb.push_back(ex(64'h0, 64'h0, 0, 0, 0, 0, 64'h0));
        check_sb("in_reset");

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            reset = 1'b1;
            drive(vecs[i].s);
            sb.push_back(vecs[i].e);
            #3;
            check_sb($sformatf("vec%0d", i));
        end

        // Mid-operation asynchronous reset.
        @(negedge clk);
        drive(mk(1, 6, 64'h66, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
        @(negedge clk);
        drive(mk(0, 0, 64'h0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0).s);
        @(negedge clk);
        drive(mk(0, 0, 64'h0, 6, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(ex(64'h66, 64'h0, 1, 0, 1, 2, 64'h0));
        #3;
        check_sb("pre_rst");
        @(posedge clk);
        #2;
        reset = 1'b0;
        drive(mk(1, 6, 64'h99, 6, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(ex(64'h0, 64'h0, 0, 0, 0, 0, 64'h0));
        #1;
        check_sb("async_rst");
        @(negedge clk);
        reset = 1'b1;
        drive(mk(0, 0, 64'h0, 6, 10, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(ex(64'h0, 64'h0, 0, 0, 0, 0, 64'h0));
        #3;
        check_sb("post_rst");
        @(negedge clk);
        drive(mk(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0).s);
        sb.push_back(ex(64'h0, 64'h0, 0, 0, 0, 1, 64'h0));
        #3;
        check_sb("first_edge");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
